// File: rtl/poly_voice_mixer.sv
// Polyphonic triangle-wave tone engine: write-only command slave with a ROM lookup
// per note-on, per-voice phase accumulators, normalised mix and sigma-delta output.
module poly_voice_mixer #(
   parameter int NUM_VOICES = 8,
   parameter int ADDR_W     = 4,
   parameter int NOTE_W     = 7,
   parameter int W          = 16,
   parameter int SAMPLE_DIV = 1024
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [NOTE_W-1:0] WDATA,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic              BREADY,
   output logic              BVALID,
   output logic [1:0]        BRESP,
   output logic [NOTE_W-1:0] inc_addr,
   input  logic [W-1:0]      inc_data,
   output logic [W-1:0]      mix_sample,
   output logic              mix_valid,
   output logic              pdm_out
);
   localparam int LOG_N = $clog2(NUM_VOICES);
   localparam int IDX_W = ADDR_W - 1;
   localparam int MIX_W = W + LOG_N;
   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam logic [IDX_W:0]   NV_LIM  = (IDX_W+1)'(NUM_VOICES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [W-1:0]     W_MSB   = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

   // Triangle fold of the phase, then offset-binary to two's complement via MSB flip.
   function automatic logic signed [W-1:0] voice_sample(input logic [W-1:0] p);
      logic [W-2:0] u;
      u = p[W-1] ? ~p[W-2:0] : p[W-2:0];
      return {~u[W-2], u[W-3:0], 1'b0};
   endfunction

   function automatic logic signed [W-1:0] normalise(input logic signed [MIX_W-1:0] s);
      logic signed [MIX_W-1:0] q;
      q = s >>> LOG_N;
      return q[W-1:0];
   endfunction

   state_t              state;
   logic                aw_held, w_held;
   logic [ADDR_W-1:0]   addr_q;
   logic [NOTE_W-1:0]   note_q;
   logic                upd;
   logic [LOG_N-1:0]    upd_voice;

   assign upd       = (state == UPDATE);
   assign upd_voice = addr_q[LOG_N-1:0];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state    <= IDLE;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         addr_q   <= '0;
         note_q   <= '0;
         BVALID   <= 1'b0;
         BRESP    <= 2'b00;
         inc_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_held && w_held) begin
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  if ({1'b0, addr_q[IDX_W-1:0]} >= NV_LIM) begin
                     state  <= RESP;
                     BVALID <= 1'b1;
                     BRESP  <= 2'b10;
                  end else if (!addr_q[ADDR_W-1]) begin
                     state <= UPDATE;
                  end else begin
                     inc_addr <= note_q;
                     state    <= LOOKUP;
                  end
               end else begin
                  if (AWVALID && AWREADY) begin
                     addr_q  <= AWADDR;
                     aw_held <= 1'b1;
                     AWREADY <= 1'b0;
                  end else if (!aw_held) begin
                     AWREADY <= 1'b1;
                  end
                  if (WVALID && WREADY) begin
                     note_q <= WDATA;
                     w_held <= 1'b1;
                     WREADY <= 1'b0;
                  end else if (!w_held) begin
                     WREADY <= 1'b1;
                  end
               end
            end
            // registered ROM presents inc_data during UPDATE
            LOOKUP: state <= UPDATE;
            UPDATE: begin
               state  <= RESP;
               BVALID <= 1'b1;
               BRESP  <= 2'b00;
            end
            RESP: begin
               if (BREADY) begin
                  state   <= IDLE;
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  WREADY  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt == CNT_MAX);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) tick_cnt <= '0;
      else          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   logic [W-1:0]          phase [NUM_VOICES];
   logic [W-1:0]          inc   [NUM_VOICES];
   logic [NUM_VOICES-1:0] active;

   // The command write comes last so it overrides a coincident tick on its voice.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            phase[i] <= '0;
            inc[i]   <= '0;
         end
         active <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++)
            if (tick && active[i]) phase[i] <= phase[i] + inc[i];
         if (upd) begin
            if (addr_q[ADDR_W-1]) begin
               inc[upd_voice]    <= inc_data;
               phase[upd_voice]  <= '0;
               active[upd_voice] <= 1'b1;
            end else begin
               active[upd_voice] <= 1'b0;
            end
         end
      end
   end

   logic signed [MIX_W-1:0] sum_c;
   logic signed [W-1:0]     vs;

   always_comb begin
      sum_c = '0;
      vs    = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         vs = voice_sample(phase[i]);
         if (active[i]) sum_c = sum_c + $signed({{LOG_N{vs[W-1]}}, vs});
      end
   end

   logic                    vld_p0, vld_p1;
   logic signed [MIX_W-1:0] sum_p1;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         sum_p1     <= '0;
         mix_valid  <= 1'b0;
         mix_sample <= '0;
      end else begin
         // p0: phases advanced by tick
         vld_p0 <= tick;
         // p1: voice sum over the advanced phases
         vld_p1 <= vld_p0;
         sum_p1 <= sum_c;
         // p2: normalised mix output
         mix_valid <= vld_p1;
         if (vld_p1) mix_sample <= normalise(sum_p1);
      end
   end

   logic [W-1:0] acc;
   logic [W:0]   sd_sum;

   assign sd_sum = {1'b0, acc} + {1'b0, mix_sample ^ W_MSB};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         acc     <= '0;
         pdm_out <= 1'b0;
      end else begin
         acc     <= sd_sum[W-1:0];
         pdm_out <= sd_sum[W];
      end
   end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Bench for poly_voice_mixer: randomized note commands against a per-tick
// phase/triangle/mix model plus a sigma-delta model of pdm_out.
`timescale 1ns/1ps
module tb_poly_voice_mixer;
   localparam int NV  = 4;
   localparam int AW  = 4;
   localparam int NW  = 7;
   localparam int W   = 16;
   localparam int DIV = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [AW-1:0] awaddr = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [NW-1:0] wdata = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic          bready = 1'b0;
   logic          bvalid;
   logic [1:0]    bresp;
   logic [NW-1:0] inc_addr;
   logic [W-1:0]  inc_data = '0;
   logic [W-1:0]  mix_sample;
   logic          mix_valid;
   logic          pdm_out;

   int n_tests = 0;
   int n_fail  = 0;

   poly_voice_mixer #(
      .NUM_VOICES(NV), .ADDR_W(AW), .NOTE_W(NW), .W(W), .SAMPLE_DIV(DIV)
   ) dut (
      .ACLK(aclk), .ARESETn(aresetn),
      .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
      .WDATA(wdata), .WVALID(wvalid), .WREADY(wready),
      .BREADY(bready), .BVALID(bvalid), .BRESP(bresp),
      .inc_addr(inc_addr), .inc_data(inc_data),
      .mix_sample(mix_sample), .mix_valid(mix_valid), .pdm_out(pdm_out)
   );

   always #5 aclk = ~aclk;

   function automatic logic [W-1:0] rom_inc(input logic [NW-1:0] n);
      if (n == 7'd60) return 16'h4000;
      return 16'(int'(n) * 517 + 11);
   endfunction

   always @(posedge aclk) inc_data <= rom_inc(inc_addr);

   function automatic int tri_val(input int p);
      if (p < 32768) return 2 * p - 32768;
      return 2 * (65535 - p) - 32768;
   endfunction

   // Reference model state
   int           m_phase [NV];
   int           m_inc   [NV];
   bit           m_active[NV];
   int           mcnt, m_mix, m_acc;
   bit           d0v, d1v, exp_valid, exp_pdm;
   int           d0m, d1m;
   logic [W-1:0] exp_mix;
   int           cmd_seq = 0, applied_seq = 0, cmd_voice = 0, cmd_inc = 0;
   bit           cmd_on = 0;

   always @(negedge aclk) begin
      int t, s, q;
      bit tk;
      if (!aresetn) begin
         for (int i = 0; i < NV; i++) begin
            m_phase[i] = 0; m_inc[i] = 0; m_active[i] = 0;
         end
         mcnt = 0; m_mix = 0; m_acc = 0;
         d0v = 0; d1v = 0; d0m = 0; d1m = 0;
         exp_valid = 0; exp_pdm = 0; exp_mix = '0;
         applied_seq = cmd_seq;
      end else begin
         t = m_acc + m_mix + 32768;
         exp_pdm = (t >= 65536);
         m_acc = t % 65536;
         if (applied_seq != cmd_seq) begin
            if (cmd_on) begin
               m_inc[cmd_voice] = cmd_inc; m_phase[cmd_voice] = 0; m_active[cmd_voice] = 1;
            end else begin
               m_active[cmd_voice] = 0;
            end
            applied_seq = cmd_seq;
         end
         tk = (mcnt == DIV - 1);
         mcnt = (mcnt + 1) % DIV;
         s = 0;
         for (int i = 0; i < NV; i++) begin
            if (tk && m_active[i]) m_phase[i] = (m_phase[i] + m_inc[i]) % 65536;
            if (m_active[i]) s += tri_val(m_phase[i]);
         end
         q = s / NV;
         if (s < 0 && (s % NV) != 0) q = q - 1;
         exp_valid = d1v;
         if (d1v) begin
            m_mix = d1m;
            exp_mix = 16'(d1m);
         end
         d1v = d0v; d1m = d0m; d0v = tk; d0m = q;
      end
   end

   task automatic wait_sample_slot();
      int c = 0;
      do begin @(negedge aclk); #1; c++; end while (!exp_valid && c < 3 * DIV);
   endtask

   task automatic pulse_reset();
      @(negedge aclk); #2; aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      #2 aresetn = 1'b1;
      @(negedge aclk); #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [NW-1:0] note,
                            input int lead, input int bdelay);
      logic [1:0] want, first_resp;
      bit aw_done = 0, w_done = 0, hs_aw, hs_w;
      int cyc = 0;
      want = (int'(addr[AW-2:0]) >= NV) ? 2'b10 : 2'b00;
      awaddr = addr; wdata = note;
      awvalid = (lead >= 0); wvalid = (lead <= 0);
      while (!(aw_done && w_done) && cyc < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(negedge aclk); #1; cyc++;
         if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
         if (hs_w)  begin wvalid = 1'b0;  w_done = 1; end
         if (lead > 0 && cyc == lead)  wvalid = 1'b1;
         if (lead < 0 && cyc == -lead) awvalid = 1'b1;
         if (aw_done && !w_done) begin
            n_tests++;
            if (awready !== 1'b0 || bvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL aw_held_wait addr=%b: awready=%b bvalid=%b, required 0 0", addr, awready, bvalid);
            end
         end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n_tests++;
      if (!(aw_done && w_done)) begin
         n_fail++;
         $display("FAIL write_capture addr=%b: aw=%0d w=%0d, required both captured", addr, aw_done, w_done);
         return;
      end
      cyc = 0;
      while (bvalid !== 1'b1 && cyc < 20) begin @(negedge aclk); #1; cyc++; end
      n_tests++;
      if (bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL bvalid_timeout addr=%b: bvalid=%b, required 1", addr, bvalid);
         return;
      end
      n_tests++;
      if (bresp !== want) begin
         n_fail++;
         $display("FAIL bresp addr=%b: got %b, required %b", addr, bresp, want);
      end
      if (want == 2'b00) begin
         cmd_voice = int'(addr[1:0]);
         cmd_on    = addr[AW-1];
         cmd_inc   = int'(rom_inc(note));
         cmd_seq++;
      end
      first_resp = bresp;
      repeat (bdelay) begin
         @(negedge aclk); #1;
         n_tests++;
         if (bvalid !== 1'b1 || bresp !== first_resp) begin
            n_fail++;
            $display("FAIL bresp_hold addr=%b: bvalid=%b bresp=%b, required 1 %b", addr, bvalid, bresp, first_resp);
         end
      end
      bready = 1'b1;
      @(negedge aclk); #1;
      bready = 1'b0;
      n_tests++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
         n_fail++;
         $display("FAIL after_resp addr=%b: bvalid=%b awready=%b wready=%b, required 0 1 1", addr, bvalid, awready, wready);
      end
   endtask

   task automatic test_reset();
      int cyc = 0, last = -1, first = -1, ones = 0;
      logic prev = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      n_tests++;
      if ({awready, wready, bvalid, bresp, mix_valid, pdm_out} !== 7'b0 ||
          mix_sample !== '0 || inc_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: aw=%b w=%b bv=%b br=%b mv=%b pdm=%b mix=%h ia=%h, required all 0",
                  awready, wready, bvalid, bresp, mix_valid, pdm_out, mix_sample, inc_addr);
      end
      #1 aresetn = 1'b1;
      repeat (4 * DIV + 4) begin
         @(negedge aclk); #1; cyc++;
         if (mix_valid === 1'b1) begin
            n_tests++;
            if (mix_sample !== '0) begin
               n_fail++;
               $display("FAIL idle_mix: got %0d, required 0", $signed(mix_sample));
            end
            if (first < 0) first = cyc;
            if (last >= 0) begin
               n_tests++;
               if (cyc - last != DIV) begin
                  n_fail++;
                  $display("FAIL idle_period: got %0d cycles, required %0d", cyc - last, DIV);
               end
            end
            last = cyc;
         end
         n_tests++;
         if (pdm_out === prev) begin
            n_fail++;
            $display("FAIL idle_pdm_alternate cycle %0d: got %b, required %b", cyc, pdm_out, ~prev);
         end
         prev = pdm_out;
         if (pdm_out === 1'b1) ones++;
      end
      n_tests++;
      if (first != DIV + 2) begin
         n_fail++;
         $display("FAIL first_mix_valid: got cycle %0d, required %0d", first, DIV + 2);
      end
      n_tests++;
      if (ones * 2 != 4 * DIV + 4 || awready !== 1'b1 || wready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_state: ones=%0d awready=%b wready=%b, required %0d 1 1", ones, awready, wready, 2 * DIV + 2);
      end
   endtask

   task automatic test_stream(input int samples);
      repeat (samples * DIV) begin
         @(negedge aclk); #1;
         n_tests++;
         if (mix_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL stream_valid: got %b, required %b", mix_valid, exp_valid);
         end else if (exp_valid && mix_sample !== exp_mix) begin
            n_fail++;
            $display("FAIL stream_mix: got %0d, required %0d", $signed(mix_sample), $signed(exp_mix));
         end
         n_tests++;
         if (pdm_out !== exp_pdm) begin
            n_fail++;
            $display("FAIL stream_pdm: got %b, required %b", pdm_out, exp_pdm);
         end
      end
   endtask

   task automatic grab_samples(input int n, output logic [W-1:0] got [4]);
      int k = 0, c = 0;
      for (int i = 0; i < 4; i++) got[i] = 'x;
      while (k < n && c < (n + 1) * DIV + 4) begin
         @(negedge aclk); #1; c++;
         if (mix_valid === 1'b1) begin got[k] = mix_sample; k++; end
      end
   endtask

   task automatic test_note_on();
      logic [W-1:0] got [4];
      logic [W-1:0] want [4];
      want = '{16'h0000, 16'd8191, 16'hFFFF, 16'hE000};
      wait_sample_slot();
      axi_write(4'b1000, 7'd60, 0, 0);
      grab_samples(4, got);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (got[i] !== want[i]) begin
            n_fail++;
            $display("FAIL note_on_seq[%0d]: got %0d, required %0d", i, $signed(got[i]), $signed(want[i]));
         end
      end
   endtask

   task automatic test_split_handshake();
      wait_sample_slot();
      axi_write(4'b1001, 7'd72, 3, 5);
      test_stream(2);
      wait_sample_slot();
      axi_write(4'b0001, 7'd0, -2, 1);
   endtask

   task automatic test_bad_index();
      logic [NW-1:0] ia;
      wait_sample_slot();
      ia = inc_addr;
      axi_write(4'b1101, 7'd33, 0, 2);
      axi_write(4'b0110, 7'd10, 1, 0);
      n_tests++;
      if (inc_addr !== ia) begin
         n_fail++;
         $display("FAIL bad_index_rom: inc_addr=%0d, required %0d", inc_addr, ia);
      end
   endtask

   task automatic test_note_off();
      logic [W-1:0] got [4];
      pulse_reset();
      wait_sample_slot();
      axi_write(4'b1000, 7'd60, 0, 0);
      axi_write(4'b1001, 7'd60, 0, 0);
      grab_samples(2, got);
      n_tests++;
      if (got[0] !== 16'd0 || got[1] !== 16'd16383) begin
         n_fail++;
         $display("FAIL two_voice_mix: got %0d %0d, required 0 16383", $signed(got[0]), $signed(got[1]));
      end
      axi_write(4'b0001, 7'd0, 0, 0);
      grab_samples(1, got);
      n_tests++;
      if (got[0] !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL note_off_mix: got %0d, required -1", $signed(got[0]));
      end
      axi_write(4'b1001, 7'd60, 0, 0);
      grab_samples(1, got);
      n_tests++;
      if (got[0] !== 16'hE000) begin
         n_fail++;
         $display("FAIL renote_mix: got %0d, required -8192", $signed(got[0]));
      end
   endtask

   task automatic test_random(input int n);
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         a = {1'($urandom_range(1)), 3'($urandom_range(5))};
         wait_sample_slot();
         axi_write(a, 7'($urandom_range(127)), int'($urandom_range(6)) - 3, int'($urandom_range(4)));
         test_stream(2);
      end
   endtask

   task automatic test_reset_lookup();
      wait_sample_slot();
      awaddr = 4'b1010; wdata = 7'd60; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk); #2;
      aresetn = 1'b0;
      repeat (3) begin
         @(negedge aclk); #1;
         n_tests++;
         if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_lookup: bvalid=%b awready=%b wready=%b, required 0 0 0", bvalid, awready, wready);
         end
      end
      #1 aresetn = 1'b1;
      repeat (DIV + 4) begin
         @(negedge aclk); #1;
         n_tests++;
         if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_bvalid: got %b, required 0", bvalid);
         end
      end
      test_stream(1);
      wait_sample_slot();
      axi_write(4'b1010, 7'd60, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream(3);
      test_note_on();
      test_stream(4);
      test_split_handshake();
      test_stream(3);
      test_bad_index();
      test_stream(2);
      test_note_off();
      test_stream(4);
      test_random(14);
      test_reset_lookup();
      test_stream(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
